// File: rtl/modulo_counter_param.sv
// -----------------------------------------------------------------------------
// modulo_counter_param
//
// Parametrised up/down modulo counter. Counts over 0..max_value (inclusive),
// with a runtime-programmable bound, count enable, direction control and a
// synchronous load. At a boundary it either wraps or saturates (SATURATE), and
// a registered terminal pulse marks every step that hits a boundary.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   When defined, an internal prescaler makes the counter step only once per
//   PRESCALE enabled clocks. When undefined, every enabled clock is a step and
//   no prescaler logic is built.
//
// Parameters:
//   WIDTH      counter / load_value / max_value width in bits
//   SATURATE   0 = wrap at boundaries, 1 = hold at boundaries
//   PRESCALE   enabled clocks per step (COUNTER_PRESCALE_EN only, >= 1)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   enable      in   count enable
//   up          in   1 = count up, 0 = count down
//   load        in   synchronous load of load_value (clamped to max_value)
//   load_value  in   value to load
//   max_value   in   inclusive upper bound of the count sequence
//   counter     out  registered count
//   terminal    out  registered one-cycle pulse on a boundary step
// -----------------------------------------------------------------------------
module modulo_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] counter,
    output logic             terminal
);

    if (PRESCALE < 1) begin : g_prescale_check
        $error("modulo_counter_param: PRESCALE must be >= 1");
    end

    logic             step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_count;
    logic             step_terminal;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler;
    logic            prescaler_last;

    assign prescaler_last = (prescaler == PS_LAST);

    // Advances on enabled cycles only; load restarts the interval.
    always_ff @(posedge clock) begin
        if (reset || load) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= prescaler_last ? '0 : prescaler + PS_W'(1);
        end
    end

    assign step = enable && prescaler_last;
`else
    assign step = enable;
`endif

    assign load_clamped = (load_value > max_value) ? max_value : load_value;

    // Next count and boundary flag for a step in the current direction.
    always_comb begin
        step_count    = counter;
        step_terminal = 1'b0;
        if (up) begin
            // >= also pulls a count left above a lowered bound back into range.
            if (counter >= max_value) begin
                step_count    = (SATURATE != 0) ? max_value : '0;
                step_terminal = 1'b1;
            end else begin
                step_count = counter + WIDTH'(1);
            end
        end else begin
            if (counter == '0) begin
                step_count    = (SATURATE != 0) ? '0 : max_value;
                step_terminal = 1'b1;
            end else if (counter > max_value) begin
                step_count = max_value;
            end else begin
                step_count = counter - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter  <= '0;
            terminal <= 1'b0;
        end else if (load) begin
            counter  <= load_clamped;
            terminal <= 1'b0;
        end else if (step) begin
            counter  <= step_count;
            terminal <= step_terminal;
        end else begin
            terminal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modulo_counter_param.sv
module tb_modulo_counter_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] max_value = 8'hA7;

    logic [7:0] counter_w, counter_s;
    logic       terminal_w, terminal_s;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clock = ~clock;

    // Wrapping instance
    modulo_counter_param #(.WIDTH(8), .SATURATE(0), .PRESCALE(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .max_value(max_value),
        .counter(counter_w), .terminal(terminal_w)
    );

    // Saturating instance
    modulo_counter_param #(.WIDTH(8), .SATURATE(1), .PRESCALE(1)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .max_value(max_value),
        .counter(counter_s), .terminal(terminal_s)
    );

`ifdef COUNTER_PRESCALE_EN
    logic [7:0] counter_p;
    logic       terminal_p;

    modulo_counter_param #(.WIDTH(8), .SATURATE(0), .PRESCALE(4)) dut_ps (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .max_value(max_value),
        .counter(counter_p), .terminal(terminal_p)
    );
`endif

    typedef struct {
        string      nm;
        bit         k0;
        logic [7:0] c0;
        logic       t0;
        bit         k1;
        logic [7:0] c1;
        logic       t1;
        bit         k2;
        logic [7:0] c2;
        logic       t2;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    task automatic clear_cur();
        cur.nm = "";
        cur.k0 = 1'b0; cur.c0 = 8'h00; cur.t0 = 1'b0;
        cur.k1 = 1'b0; cur.c1 = 8'h00; cur.t1 = 1'b0;
        cur.k2 = 1'b0; cur.c2 = 8'h00; cur.t2 = 1'b0;
    endtask

    task automatic drv(input logic r, input logic en, input logic u, input logic ld,
                       input logic [7:0] lv, input logic [7:0] mx);
        reset = r; enable = en; up = u; load = ld; load_value = lv; max_value = mx;
    endtask

    task automatic ew(input string nm, input logic [7:0] c, input logic t);
        cur.nm = nm; cur.k0 = 1'b1; cur.c0 = c; cur.t0 = t;
    endtask

    task automatic es(input string nm, input logic [7:0] c, input logic t);
        cur.nm = nm; cur.k1 = 1'b1; cur.c1 = c; cur.t1 = t;
    endtask

    task automatic eb(input string nm, input logic [7:0] c, input logic t);
        ew(nm, c, t);
        es(nm, c, t);
    endtask

    task automatic ep(input string nm, input logic [7:0] c, input logic t);
        cur.nm = nm; cur.k2 = 1'b1; cur.c2 = c; cur.t2 = t;
    endtask

    // Queue the expectation for the coming edge, then move to the next cycle.
    task automatic go();
        q.push_back(cur);
        clear_cur();
        @(negedge clock);
    endtask

    task automatic cmp(input string nm, input string which,
                       input logic [7:0] got_c, input logic got_t,
                       input logic [7:0] req_c, input logic req_t);
        checks++;
        if (got_c !== req_c || got_t !== req_t) begin
            errors++;
            $display("FAIL %s/%s: got counter=%h terminal=%b, required counter=%h terminal=%b",
                     nm, which, got_c, got_t, req_c, req_t);
        end
    endtask

    // Monitor: one queued expectation per clock edge, sampled after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.k0) cmp(x.nm, "wrap", counter_w, terminal_w, x.c0, x.t0);
                if (x.k1) cmp(x.nm, "sat", counter_s, terminal_s, x.c1, x.t1);
`ifdef COUNTER_PRESCALE_EN
                if (x.k2) cmp(x.nm, "ps", counter_p, terminal_p, x.c2, x.t2);
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_cur();
        @(negedge clock);

        // Reset, then count up from zero
        drv(1, 1, 1, 0, 8'h00, 8'hA7); eb("reset_a", 8'h00, 0); go();
        drv(1, 1, 1, 0, 8'h00, 8'hA7); eb("reset_b", 8'h00, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hA7); eb("up_1", 8'h01, 0); go();
        eb("up_2", 8'h02, 0); go();
        eb("up_3", 8'h03, 0); go();
        drv(0, 1, 1, 1, 8'h33, 8'hA7); eb("load_33", 8'h33, 0); go();
        drv(1, 1, 1, 1, 8'h50, 8'hA7); eb("reset_over_load", 8'h00, 0); go();

        // Wrap at A7 and a full 168-clock period; saturating copy parks at A7
        drv(0, 0, 1, 1, 8'hA5, 8'hA7); eb("load_a5", 8'hA5, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hA7); eb("up_a6", 8'hA6, 0); go();
        eb("up_a7", 8'hA7, 0); go();
        ew("wrap_00", 8'h00, 1); es("sat_hold_a", 8'hA7, 1); go();
        ew("after_wrap", 8'h01, 0); es("sat_hold_b", 8'hA7, 1); go();
        for (int i = 2; i <= 167; i++) begin
            ew("period_run", 8'(i), 0); es("sat_hold_run", 8'hA7, 1); go();
        end
        ew("period_wrap", 8'h00, 1); es("sat_hold_end", 8'hA7, 1); go();

        // Count down through zero; lowered max while above it
        drv(0, 1, 0, 0, 8'h00, 8'hA7); ew("down_wrap", 8'hA7, 1); es("sat_down", 8'hA6, 0); go();
        ew("down_a6", 8'hA6, 0); es("sat_down_a5", 8'hA5, 0); go();
        drv(0, 1, 1, 1, 8'h90, 8'hA7); eb("load_90", 8'h90, 0); go();
        drv(0, 1, 0, 0, 8'h00, 8'h40); eb("down_above_max", 8'h40, 0); go();
        drv(0, 1, 1, 1, 8'h90, 8'hA7); eb("load_90_b", 8'h90, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'h40); ew("up_above_max", 8'h00, 1); es("sat_up_above_max", 8'h40, 1); go();
        drv(0, 1, 0, 1, 8'h01, 8'hA7); eb("load_01", 8'h01, 0); go();
        drv(0, 1, 0, 0, 8'h00, 8'hA7); eb("down_00", 8'h00, 0); go();
        ew("down_wrap_b", 8'hA7, 1); es("sat_floor_a", 8'h00, 1); go();
        ew("down_a6_b", 8'hA6, 0); es("sat_floor_b", 8'h00, 1); go();

        // Load priority and clamping
        drv(0, 1, 1, 1, 8'h50, 8'hA7); eb("load_wins", 8'h50, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hA7); eb("after_load", 8'h51, 0); go();
        drv(0, 1, 1, 1, 8'hF0, 8'hA7); eb("load_clamp", 8'hA7, 0); go();
        drv(0, 1, 1, 1, 8'hA6, 8'hA7); eb("load_a6", 8'hA6, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hA7); eb("step_a7", 8'hA7, 0); go();
        drv(0, 1, 1, 1, 8'hA7, 8'hA7); eb("load_at_max", 8'hA7, 0); go();
        drv(0, 0, 1, 0, 8'h00, 8'hA7); eb("hold_a", 8'hA7, 0); go();
        eb("hold_b", 8'hA7, 0); go();

        // max_value = 0: stays at zero, every step pulses
        drv(0, 1, 1, 1, 8'h33, 8'h00); eb("load_max0", 8'h00, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'h00); eb("max0_up_a", 8'h00, 1); go();
        eb("max0_up_b", 8'h00, 1); go();
        drv(0, 1, 0, 0, 8'h00, 8'h00); eb("max0_down", 8'h00, 1); go();

        // Full-range bound
        drv(0, 1, 1, 1, 8'hFE, 8'hFF); eb("load_fe", 8'hFE, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hFF); eb("full_ff", 8'hFF, 0); go();
        ew("full_wrap", 8'h00, 1); es("full_sat", 8'hFF, 1); go();

`ifdef COUNTER_PRESCALE_EN
        // One step per four enabled clocks; enable low freezes the interval
        drv(1, 0, 1, 0, 8'h00, 8'hA7); ep("ps_reset", 8'h00, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hA7);
        for (int i = 0; i < 3; i++) begin ep("ps_wait", 8'h00, 0); go(); end
        ep("ps_step1", 8'h01, 0); go();
        ep("ps_mid_a", 8'h01, 0); go();
        ep("ps_mid_b", 8'h01, 0); go();
        drv(0, 0, 1, 0, 8'h00, 8'hA7);
        for (int i = 0; i < 3; i++) begin ep("ps_frozen", 8'h01, 0); go(); end
        drv(0, 1, 1, 0, 8'h00, 8'hA7); ep("ps_mid_c", 8'h01, 0); go();
        ep("ps_step2", 8'h02, 0); go();
        ep("ps_part", 8'h02, 0); go();
        drv(0, 1, 1, 1, 8'h10, 8'hA7); ep("ps_load", 8'h10, 0); go();
        drv(0, 1, 1, 0, 8'h00, 8'hA7);
        for (int i = 0; i < 3; i++) begin ep("ps_restart", 8'h10, 0); go(); end
        ep("ps_step3", 8'h11, 0); go();
`endif

        drv(0, 0, 1, 0, 8'h00, 8'hA7);
        repeat (3) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
